// File: rtl/axis_frame_buffer.sv
// Circular AXI-Stream beat buffer with optional store-and-forward framing.
// Frames are released once their tlast beat is stored; an oversized frame is force-committed and streamed.
module axis_frame_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10,
   parameter int FRAME_MODE = 1
) (
   input  logic                    axis_aclk,
   input  logic                    axis_areset,
   input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
   input  logic                    s01_axis_tvalid,
   input  logic                    s01_axis_tlast,
   output logic                    s01_axis_tready,
   output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
   output logic                    m01_axis_tvalid,
   output logic                    m01_axis_tlast,
   input  logic                    m01_axis_tready,
   output logic [ADDR_WIDTH:0]     fill_level,
   output logic [ADDR_WIDTH:0]     frame_count,
   output logic                    oversize_err
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int BEAT_WIDTH = DATA_WIDTH + STRB_WIDTH + 1;
   localparam int PTR_WIDTH  = ADDR_WIDTH + 1;
   localparam logic [PTR_WIDTH-1:0] DEPTH = PTR_WIDTH'(2 ** ADDR_WIDTH);
   localparam bit FRAME = (FRAME_MODE != 0);

   logic [BEAT_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

   logic [PTR_WIDTH-1:0]  wr_ptr_reg, wr_ptr_next;
   logic [PTR_WIDTH-1:0]  commit_ptr_reg, commit_ptr_next;
   logic [PTR_WIDTH-1:0]  rd_ptr_reg, rd_ptr_next;
   logic [PTR_WIDTH-1:0]  frame_count_reg, frame_count_next;
   logic                  stream_reg, stream_next;
   logic                  oversize_reg, oversize_next;
   logic                  out_valid_reg, out_valid_next;
   logic [BEAT_WIDTH-1:0] out_beat_reg;

   logic [PTR_WIDTH-1:0]  fill;
   logic                  wr_en;
   logic                  load_ok;
   logic                  load_en;
   logic                  force_commit;
   logic                  emit_last;
   logic                  frame_inc;

   assign fill            = wr_ptr_reg - rd_ptr_reg;
   assign s01_axis_tready = !axis_areset && (fill != DEPTH);
   assign wr_en           = s01_axis_tvalid && s01_axis_tready;
   assign load_ok         = !out_valid_reg || m01_axis_tready;
   assign load_en         = load_ok && (rd_ptr_reg != commit_ptr_reg);
   // A full buffer with nothing committed can only hold one partial frame: release it.
   assign force_commit    = FRAME && (fill == DEPTH) && (commit_ptr_reg == rd_ptr_reg);
   assign emit_last       = out_valid_reg && m01_axis_tready && out_beat_reg[BEAT_WIDTH-1];

   always_comb begin
      wr_ptr_next      = wr_ptr_reg + PTR_WIDTH'(wr_en);
      rd_ptr_next      = rd_ptr_reg + PTR_WIDTH'(load_en);
      commit_ptr_next  = commit_ptr_reg;
      stream_next      = stream_reg;
      oversize_next    = 1'b0;
      frame_inc        = 1'b0;
      frame_count_next = frame_count_reg;
      out_valid_next   = out_valid_reg;

      if (!FRAME) begin
         commit_ptr_next = wr_ptr_next;
         frame_inc       = wr_en && s01_axis_tlast;
      end else if (force_commit) begin
         commit_ptr_next = wr_ptr_reg;
         stream_next     = 1'b1;
         oversize_next   = 1'b1;
         frame_inc       = 1'b1;
      end else if (wr_en) begin
         // After a forced commit the remainder of that frame is committed beat by beat.
         if (stream_reg || s01_axis_tlast) begin
            commit_ptr_next = wr_ptr_next;
         end
         if (s01_axis_tlast) begin
            stream_next = 1'b0;
            frame_inc   = !stream_reg;
         end
      end

      if (frame_inc && !emit_last) begin
         frame_count_next = frame_count_reg + PTR_WIDTH'(1);
      end else if (!frame_inc && emit_last) begin
         frame_count_next = frame_count_reg - PTR_WIDTH'(1);
      end

      if (load_en) begin
         out_valid_next = 1'b1;
      end else if (load_ok) begin
         out_valid_next = 1'b0;
      end
   end

   always_ff @(posedge axis_aclk) begin
      if (wr_en) begin
         mem[wr_ptr_reg[ADDR_WIDTH-1:0]] <= {s01_axis_tlast, s01_axis_tstrb, s01_axis_tdata};
      end
   end

   always_ff @(posedge axis_aclk) begin
      if (axis_areset) begin
         out_beat_reg <= '0;
      end else if (load_en) begin
         out_beat_reg <= mem[rd_ptr_reg[ADDR_WIDTH-1:0]];
      end
   end

   always_ff @(posedge axis_aclk) begin
      if (axis_areset) begin
         wr_ptr_reg      <= '0;
         commit_ptr_reg  <= '0;
         rd_ptr_reg      <= '0;
         frame_count_reg <= '0;
         stream_reg      <= 1'b0;
         oversize_reg    <= 1'b0;
         out_valid_reg   <= 1'b0;
      end else begin
         wr_ptr_reg      <= wr_ptr_next;
         commit_ptr_reg  <= commit_ptr_next;
         rd_ptr_reg      <= rd_ptr_next;
         frame_count_reg <= frame_count_next;
         stream_reg      <= stream_next;
         oversize_reg    <= oversize_next;
         out_valid_reg   <= out_valid_next;
      end
   end

   assign m01_axis_tdata  = out_beat_reg[DATA_WIDTH-1:0];
   assign m01_axis_tstrb  = out_beat_reg[DATA_WIDTH +: STRB_WIDTH];
   assign m01_axis_tlast  = out_beat_reg[BEAT_WIDTH-1];
   assign m01_axis_tvalid = out_valid_reg;
   assign fill_level      = fill;
   assign frame_count     = frame_count_reg;
   assign oversize_err    = oversize_reg;
endmodule

// File: tb/tb_axis_frame_buffer.sv
// Bench for axis_frame_buffer: FIFO and frame instances (depth 16) checked every cycle
// against a queue-level model of buffer contents, committed beats and frame counts.
module tb_axis_frame_buffer;
   localparam int DEPTH = 16;

   typedef struct packed {
      logic        last;
      logic [3:0]  strb;
      logic [31:0] data;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        sel;
   logic [31:0] s_data;
   logic [3:0]  s_strb;
   logic        s_valid;
   logic        s_last;
   logic        m_ready;

   logic [1:0]  s_valid_w, tready_w, ovalid_w, olast_w, oerr_w;
   logic [31:0] odata_w [2];
   logic [3:0]  ostrb_w [2];
   logic [4:0]  fill_w [2];
   logic [4:0]  fcnt_w [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      assign s_valid_w[gi] = s_valid && (sel == 1'(gi));
      axis_frame_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .FRAME_MODE(gi)) u_dut (
         .axis_aclk       (clk),
         .axis_areset     (rst),
         .s01_axis_tdata  (s_data),
         .s01_axis_tstrb  (s_strb),
         .s01_axis_tvalid (s_valid_w[gi]),
         .s01_axis_tlast  (s_last),
         .s01_axis_tready (tready_w[gi]),
         .m01_axis_tdata  (odata_w[gi]),
         .m01_axis_tstrb  (ostrb_w[gi]),
         .m01_axis_tvalid (ovalid_w[gi]),
         .m01_axis_tlast  (olast_w[gi]),
         .m01_axis_tready (m_ready),
         .fill_level      (fill_w[gi]),
         .frame_count     (fcnt_w[gi]),
         .oversize_err    (oerr_w[gi])
      );
   end

   logic        tready, ovalid, olast, oerr;
   logic [31:0] odata;
   logic [3:0]  ostrb;
   logic [4:0]  fill, fcnt;
   assign tready = tready_w[sel];
   assign ovalid = ovalid_w[sel];
   assign olast  = olast_w[sel];
   assign oerr   = oerr_w[sel];
   assign odata  = odata_w[sel];
   assign ostrb  = ostrb_w[sel];
   assign fill   = fill_w[sel];
   assign fcnt   = fcnt_w[sel];

   // Reference model: queue of stored beats, how many at its head are releasable, output slot.
   beat_t mq[$];
   int    n_commit;
   bit    out_v;
   beat_t out_b;
   int    frames;
   bit    streaming;
   bit    pulse;
   bit    acc_m;
   int    osz_seen;
   int    total = 0;
   int    bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got=%0h exp=%0h", tag, $time, got, exp);
      end
   endtask

   task automatic check_all();
      check("s_tready", 32'(tready), 32'(!rst && mq.size() != DEPTH));
      check("m_tvalid", 32'(ovalid), 32'(out_v));
      check("m_tdata", odata, out_b.data);
      check("m_tstrb", 32'(ostrb), 32'(out_b.strb));
      check("m_tlast", 32'(olast), 32'(out_b.last));
      check("fill_level", 32'(fill), 32'(mq.size()));
      check("frame_count", 32'(fcnt), 32'(frames));
      check("oversize_err", 32'(oerr), 32'(pulse));
      if (oerr === 1'b1) osz_seen++;
   endtask

   task automatic model_step();
      bit    full, load_ok, emit, load, frc;
      beat_t b;
      acc_m = 1'b0;
      if (rst) begin
         mq.delete();
         n_commit  = 0;
         out_v     = 1'b0;
         out_b     = '0;
         frames    = 0;
         streaming = 1'b0;
         pulse     = 1'b0;
         return;
      end
      full    = (mq.size() == DEPTH);
      acc_m   = s_valid && !full;
      load_ok = !out_v || m_ready;
      emit    = out_v && m_ready;
      load    = load_ok && (n_commit > 0);
      frc     = sel && full && (n_commit == 0);
      pulse   = frc;
      if (emit) begin
         $display("beat out mode=%0d data=%08h strb=%h last=%0d", sel, out_b.data, out_b.strb, out_b.last);
         if (out_b.last) frames--;
      end
      if (load) begin
         out_b = mq.pop_front();
         n_commit--;
         out_v = 1'b1;
      end else if (load_ok) begin
         out_v = 1'b0;
      end
      if (acc_m) begin
         b.last = s_last;
         b.strb = s_strb;
         b.data = s_data;
         mq.push_back(b);
         if (!sel || streaming) n_commit++;
         else if (s_last) n_commit = mq.size();
         if (s_last) begin
            if (!streaming) frames++;
            streaming = 1'b0;
         end
      end
      if (frc) begin
         n_commit  = mq.size();
         frames++;
         streaming = 1'b1;
      end
   endtask

   task automatic tick(input bit v, input logic [31:0] d, input logic [3:0] st, input bit l, input bit r);
      @(negedge clk);
      check_all();
      rst     = 1'b0;
      s_valid = v;
      s_data  = d;
      s_strb  = st;
      s_last  = l;
      m_ready = r;
      model_step();
   endtask

   task automatic reset_to(input bit mode);
      @(negedge clk);
      check_all();
      sel     = mode;
      rst     = 1'b1;
      s_valid = 1'b0;
      m_ready = 1'b0;
      model_step();
   endtask

   function automatic bit ready_of(input int pol, input int k);
      case (pol)
         0:       return 1'b1;
         1:       return 1'b0;
         2:       return k[0];
         default: return 1'($urandom_range(1, 0));
      endcase
   endfunction

   task automatic send(input int n, input logic [31:0] base, input bit last_end, input int pol);
      int i = 0;
      int k = 0;
      bit v;
      while (i < n && k < 1000) begin
         v = (pol == 3) ? ($urandom_range(3, 0) != 0) : 1'b1;
         tick(v, base + 32'(i), 4'(i) ^ 4'hA, last_end && (i == n - 1), ready_of(pol, k));
         if (acc_m) i++;
         k++;
      end
      if (i < n) check("send_timeout", 32'(i), 32'(n));
   endtask

   task automatic drain(input int pol);
      int k = 0;
      while ((mq.size() != 0 || out_v) && k < 500) begin
         tick(1'b0, 32'h0, 4'h0, 1'b0, ready_of(pol, k));
         k++;
      end
      tick(1'b0, 32'h0, 4'h0, 1'b0, 1'b1);
      if (k >= 500) check("drain_timeout", 32'(k), 32'(0));
   endtask

   initial begin
      int i;
      int k;
      rst = 1'b1; sel = 1'b0; s_valid = 1'b0; s_data = '0; s_strb = '0; s_last = 1'b0; m_ready = 1'b0;
      mq.delete(); n_commit = 0; out_v = 1'b0; out_b = '0; frames = 0; streaming = 1'b0; pulse = 1'b0;
      repeat (2) @(posedge clk);

      // FIFO mode: three beats, tlast on the third
      reset_to(1'b0);
      tick(1'b1, 32'h11, 4'hF, 1'b0, 1'b1);
      tick(1'b1, 32'h22, 4'hF, 1'b0, 1'b1);
      tick(1'b1, 32'h33, 4'hF, 1'b1, 1'b1);
      drain(0);

      // Frame mode: 5-beat frame held until tlast
      reset_to(1'b1);
      send(5, 32'hA0, 1'b1, 0);
      drain(0);

      // FIFO fill to full with consumer stalled, one release, then continue across wrap
      reset_to(1'b0);
      i = 0;
      repeat (20) begin
         tick(1'b1, 32'h300 + 32'(i), 4'(i), 1'b0, 1'b0);
         if (acc_m) i++;
      end
      tick(1'b1, 32'h300 + 32'(i), 4'(i), 1'b0, 1'b1);
      if (acc_m) i++;
      k = 0;
      while (i < 40 && k < 500) begin
         tick(1'b1, 32'h300 + 32'(i), 4'(i), i == 39, 1'($urandom_range(1, 0)));
         if (acc_m) i++;
         k++;
      end
      check("wrap_beats", 32'(i), 32'd40);
      drain(0);

      // Frame mode: 20-beat frame overflows the buffer, forcing a commit
      reset_to(1'b1);
      osz_seen = 0;
      send(20, 32'hB00, 1'b1, 0);
      drain(0);
      check("oversize_pulses", 32'(osz_seen), 32'd1);

      // Backpressure toggling every cycle during a 10-beat stream
      reset_to(1'b0);
      send(10, 32'hC00, 1'b1, 2);
      drain(2);

      // Reset mid-frame with 6 beats stored, then a 2-beat frame
      reset_to(1'b1);
      send(6, 32'hD00, 1'b0, 1);
      reset_to(1'b1);
      send(2, 32'hE00, 1'b1, 0);
      drain(0);

      // Randomized frames and backpressure in both modes
      for (int m = 0; m < 2; m++) begin
         reset_to(1'(m));
         for (int f = 0; f < 30; f++) begin
            send($urandom_range(6, 1), $urandom, 1'b1, 3);
         end
         drain(3);
      end

      @(negedge clk);
      check_all();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
